// File: rtl/mem_responder.sv
// Multicycle word-memory responder: latches one MemRead/MemWrite request, waits WAIT_STATES cycles, accesses RAM, pulses mem_ready.
// Optional feature: define MEM_PARITY_EN to store and check one even-parity bit per word.
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              addr_err,
  output logic              parity_err
);

  // state  | meaning
  // S_IDLE | sampling MemRead/MemWrite
  // S_WAIT | counting wait states; access happens when cnt reaches 0
  // S_RESP | mem_ready pulse, error flags valid, back to S_IDLE next edge

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
      $error("mem_responder: WAIT_STATES must be 0..15");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
      $error("mem_responder: DEPTH must be 1..2**ADDR_W");
    end
  endgenerate

`ifdef MEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [RAM_W-1:0]  mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [RAM_W-1:0]  rd_word;
  logic [RAM_W-1:0]  wr_word;
  logic              in_range;
  logic              ram_we;

  assign idx      = addr_q[IDX_W-1:0];
  assign in_range = ({1'b0, addr_q} < DEPTH_C);
  assign rd_word  = mem[idx];
  // write commits only on the access edge, so a reset during S_WAIT drops it
  assign ram_we   = (state == S_WAIT) && (cnt == 4'd0) && op_wr && in_range;

`ifdef MEM_PARITY_EN
  assign wr_word = {^wdata_q, wdata_q};
  logic par_q;
  assign parity_err = par_q;
`else
  assign wr_word = wdata_q;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      addr_err  <= 1'b0;
`ifdef MEM_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      mem_ready <= 1'b0;
      addr_err  <= 1'b0;
`ifdef MEM_PARITY_EN
      par_q     <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (MemRead ^ MemWrite) begin
            op_wr   <= MemWrite;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= 4'(WAIT_STATES);
            state   <= S_WAIT;
            busy    <= 1'b1;
          end else if (MemRead && MemWrite) begin
            state     <= S_RESP;
            busy      <= 1'b1;
            mem_ready <= 1'b1;
            addr_err  <= 1'b1;
            rdata     <= '0;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= S_RESP;
            mem_ready <= 1'b1;
            if (!in_range) begin
              addr_err <= 1'b1;
              rdata    <= '0;
            end else if (!op_wr) begin
              rdata <= rd_word[DATA_W-1:0];
`ifdef MEM_PARITY_EN
              par_q <= (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];
`endif
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: main instance DEPTH=200/WAIT_STATES=2, side instance WAIT_STATES=0.
module tb_mem_responder;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int WS    = 2;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          aerr;
    logic          perr;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          MemRead, MemWrite;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic          mem_ready, busy, addr_err, parity_err;

  logic          mr0, mw0;
  logic [AW-1:0] a0;
  logic [DW-1:0] wd0, rd0;
  logic          rdy0, busy0, ae0, pe0;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            rdy_count = 0;
  exp_t          sb_q[$];
  logic [DW-1:0] model_mem [256];
  bit            model_pbad [256];
  logic [DW-1:0] model_rdata;

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
    .rdata(rdata), .mem_ready(mem_ready), .busy(busy), .addr_err(addr_err), .parity_err(parity_err)
  );

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .MemRead(mr0), .MemWrite(mw0), .addr(a0), .wdata(wd0),
    .rdata(rd0), .mem_ready(rdy0), .busy(busy0), .addr_err(ae0), .parity_err(pe0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && mem_ready === 1'b1) begin
      rdy_count++;
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("rdata", {16'h0, rdata}, {16'h0, e.rdata});
        check("addr_err", {31'h0, addr_err}, {31'h0, e.aerr});
        check("parity_err", {31'h0, parity_err}, {31'h0, e.perr});
      end
    end
  end

  // Called at posedge+1 with the main instance idle; returns at posedge+1 back in idle.
  task automatic req(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    int   n;
    int   lat;
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = d;
    e.perr   = 1'b0;
    if (rd && wr) begin
      lat         = 0;
      model_rdata = '0;
      e.aerr      = 1'b1;
    end else begin
      lat = WS + 1;
      if (int'(a) >= DEPTH) begin
        model_rdata = '0;
        e.aerr      = 1'b1;
      end else begin
        e.aerr = 1'b0;
        if (wr) begin
          model_mem[a]  = d;
          model_pbad[a] = 1'b0;
        end else begin
          model_rdata = model_mem[a];
          e.perr      = model_pbad[a];
        end
      end
    end
    e.rdata = model_rdata;
    sb_q.push_back(e);
    @(posedge clk); #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    n = 0;
    while (mem_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, lat);
    check("busy_resp", {31'h0, busy}, 1);
    @(posedge clk); #1;
    check("ready_width", {31'h0, mem_ready}, 0);
    check("busy_idle", {31'h0, busy}, 0);
  endtask

  initial begin
    int n;
    int r0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int r0;
    rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
    mr0 = 1'b0; mw0 = 1'b0; a0 = '0; wd0 = '0;
    model_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      model_mem[i]  = '0;
      model_pbad[i] = 1'b0;
    end
    #12;
    check("rst_rdata", {16'h0, rdata}, 0);
    check("rst_ready", {31'h0, mem_ready}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_aerr", {31'h0, addr_err}, 0);
    check("rst_perr", {31'h0, parity_err}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // reset aborts an in-flight write
    req(1'b0, 1'b1, 8'h05, 16'hBEEF);
    req(1'b1, 1'b0, 8'h05, 16'h0000);
    MemWrite = 1'b1; addr = 8'h05; wdata = 16'h1234;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", {31'h0, busy}, 1);
    rst = 1'b0;
    #1;
    check("abort_rdata", {16'h0, rdata}, 0);
    check("abort_ready", {31'h0, mem_ready}, 0);
    check("abort_busy0", {31'h0, busy}, 0);
    check("abort_aerr", {31'h0, addr_err}, 0);
    check("abort_perr", {31'h0, parity_err}, 0);
    model_rdata = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    req(1'b1, 1'b0, 8'h05, 16'h0000);

    // basic write/read, write keeps rdata
    req(1'b0, 1'b1, 8'h10, 16'hA5C3);
    req(1'b1, 1'b0, 8'h10, 16'h0000);
    req(1'b0, 1'b1, 8'h11, 16'h3C5A);
    req(1'b1, 1'b0, 8'h11, 16'h0000);

    // range boundaries
    req(1'b0, 1'b1, 8'h00, 16'h1111);
    req(1'b0, 1'b1, 8'hC7, 16'h2222);
    req(1'b1, 1'b0, 8'hF0, 16'h0000);
    req(1'b0, 1'b1, 8'hC8, 16'hFFFF);
    req(1'b1, 1'b0, 8'hC7, 16'h0000);
    req(1'b1, 1'b0, 8'h00, 16'h0000);

    // both strobes: immediate error response, no RAM change
    req(1'b1, 1'b1, 8'h10, 16'h0BAD);
    req(1'b1, 1'b0, 8'h10, 16'h0000);

    // strobe during WAIT is ignored
    r0 = rdy_count;
    model_rdata = model_mem[8'h11];
    sb_q.push_back('{rdata: model_mem[8'h11], aerr: 1'b0, perr: 1'b0});
    MemRead = 1'b1; addr = 8'h11;
    @(posedge clk); #1;
    MemRead = 1'b0;
    @(posedge clk); #1;
    MemRead = 1'b1; addr = 8'h10;
    @(posedge clk); #1;
    MemRead = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("single_ready", rdy_count - r0, 1);

    // parity path
    req(1'b0, 1'b1, 8'h20, 16'h0001);
`ifdef MEM_PARITY_EN
    u_dut.mem[8'h20][16] = ~u_dut.mem[8'h20][16];
    model_pbad[8'h20] = 1'b1;
`endif
    req(1'b1, 1'b0, 8'h20, 16'h0000);

    // zero wait states: ready one edge after sampling
    mw0 = 1'b1; a0 = 8'h03; wd0 = 16'h5A5A;
    @(posedge clk); #1;
    mw0 = 1'b0;
    check("ws0_wr_early", {31'h0, rdy0}, 0);
    @(posedge clk); #1;
    check("ws0_wr_ready", {31'h0, rdy0}, 1);
    @(posedge clk); #1;
    check("ws0_wr_width", {31'h0, rdy0}, 0);
    mr0 = 1'b1;
    @(posedge clk); #1;
    mr0 = 1'b0;
    check("ws0_rd_early", {31'h0, rdy0}, 0);
    @(posedge clk); #1;
    check("ws0_rd_ready", {31'h0, rdy0}, 1);
    check("ws0_rd_data", {16'h0, rd0}, 32'h5A5A);
    check("ws0_aerr", {31'h0, ae0}, 0);
    check("ws0_perr", {31'h0, pe0}, 0);
    check("ws0_busy", {31'h0, busy0}, 1);
    @(posedge clk); #1;

    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
